timer_ctrl: RTL
===============

Name: timer_ctrl

Overview:
- Control stage wrapped around the team's generic up/down counter (clk_i/rst_ni, clear/en/load/down/d_i/q_o/overflow_o).
- Drives the counter's clear, enable, load and direction inputs from a prescaler and a compare/terminal FSM.
- Consumes the counter's q_o and overflow_o.
- Produces a sticky interrupt with acknowledge and a missed-event flag. This is the timer core used by peripheral timers.

Parameters:
- WIDTH, 16, counter width; must equal the attached counter's WIDTH.
- PRESC_WIDTH, 8, prescaler width; tick period = cfg_presc_i+1 cycles.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- cfg_en_i  in  1  timer enable; low forces stop
- cfg_oneshot_i  in  1  1 = one-shot, 0 = periodic
- cfg_down_i  in  1  1 = count cmp..0, 0 = count 0..cmp
- cfg_presc_i  in  PRESC_WIDTH  prescaler terminal value
- cfg_cmp_i  in  WIDTH  compare/reload value
- start_i  in  1  start pulse
- stop_i  in  1  stop pulse
- irq_ack_i  in  1  clears pending interrupt
- cnt_q_i  in  WIDTH  counter value (counter q_o)
- cnt_overflow_i  in  1  counter overflow_o
- cnt_clear_o  out  1  to counter clear_i
- cnt_en_o  out  1  to counter en_i
- cnt_load_o  out  1  to counter load_i
- cnt_down_o  out  1  to counter down_i
- cnt_d_o  out  WIDTH  to counter d_i
- running_o  out  1  high in LOAD/RUN
- irq_o  out  1  sticky interrupt pending
- miss_o  out  1  sticky: event while irq_o already pending
- err_o  out  1  sticky: cnt_overflow_i seen while running

Behaviour:
- Reset (rst_i=1 at edge):
  - State IDLE, prescaler count 0, shadow regs 0.
  - irq_o, miss_o and err_o are 0; all cnt_* outputs are 0.
  - Reset mid-run aborts with no clear pulse.
- Shadow registers:
  - cfg_oneshot_i, cfg_down_i, cfg_presc_i and cfg_cmp_i are captured when leaving IDLE/DONE to LOAD.
  - Config changes mid-run are ignored until the next start.
  - cnt_down_o is driven from the shadow direction bit.
- IDLE:
  - start_i & cfg_en_i -> LOAD; otherwise stay.
  - start_i with cfg_en_i low is ignored.
- LOAD (exactly 1 cycle):
  - cnt_load_o=1 and cnt_en_o=0.
  - cnt_d_o = shadow cmp if down, else 0.
  - Prescaler cleared; err_o cleared. Next state RUN.
- RUN:
  - Prescaler increments each cycle. tick = (presc_cnt == shadow presc); on tick, presc_cnt <= 0.
  - terminal = 0 if down, else shadow cmp.
  - Event = tick & (cnt_q_i == terminal).
  - tick without event: cnt_en_o=1 for that cycle.
  - Event, periodic: cnt_load_o=1, cnt_en_o=0, same cnt_d_o as LOAD; stay RUN.
  - Event, one-shot: cnt_en_o=0 and cnt_load_o=0; go to DONE.
  - Resulting period = (cmp+1)*(presc+1) cycles. presc=0 ticks every cycle; cmp=0 gives an event on every tick.
- Stop:
  - stop_i, or cfg_en_i low, in LOAD/RUN -> IDLE with cnt_clear_o=1 for one cycle.
  - In that cycle cnt_en_o=0 and cnt_load_o=0; stop overrides a coincident event (no irq).
  - stop_i in IDLE/DONE has no effect.
- DONE:
  - Counter outputs idle and the counter value is held.
  - start_i & cfg_en_i -> LOAD; stop_i -> IDLE with cnt_clear_o pulse.
- Interrupt (registered):
  - Event sets irq_o the next cycle. irq_ack_i clears it.
  - Event and ack in the same cycle: irq_o stays 1, no miss.
  - Event while irq_o=1 and no ack: miss_o <= 1.
  - miss_o clears on irq_ack_i only when no event is present in that cycle.
- err_o: set when cnt_overflow_i=1 in RUN; cleared only in LOAD or by reset.
- start_i while in LOAD/RUN is ignored (no restart).

Test Plan:
- Up periodic, presc=2, cmp=3, start at cycle 0: LOAD at cycle 1; cnt_q_i walks 0,1,2,3 with 3 cycles per step. First irq_o rise at cycle 14, then every 12 cycles, with cnt_load_o pulsing on each event.
- Down one-shot, presc=0, cmp=5: counter runs 5,4,3,2,1,0. Exactly one event, then state DONE with running_o=0 and cnt_q_i held at 0. irq_o=1 until ack; a later start reloads 5.
- Never ack, periodic, presc=0, cmp=1: second event sets miss_o=1. Ack coincident with the third event leaves irq_o=1 and miss_o=1; a plain ack afterwards clears both.
- stop_i asserted in the same cycle as an event: cnt_clear_o=1 one cycle, no irq, state IDLE. Changing cfg_cmp_i mid-run does not change the period.
- Force cnt_overflow_i=1 in RUN: err_o=1 and persists until the next LOAD. Apply rst_i mid-run: all outputs 0 the next cycle.

Source files
------------

// File: rtl/timer_ctrl.sv
// Control stage for the generic up/down counter: prescaled ticks, compare/terminal
// detection, periodic or one-shot operation, and sticky irq/miss/err flags.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stopped, waiting for start with timer enabled
// LOAD  | one cycle: load the counter start value, clear prescaler and err
// RUN   | prescaler ticking, counter stepping towards the terminal value
// DONE  | one-shot finished, counter value held until start or stop
module timer_ctrl #(
   parameter int WIDTH       = 16,
   parameter int PRESC_WIDTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   cfg_en_i,
   input  logic                   cfg_oneshot_i,
   input  logic                   cfg_down_i,
   input  logic [PRESC_WIDTH-1:0] cfg_presc_i,
   input  logic [WIDTH-1:0]       cfg_cmp_i,
   input  logic                   start_i,
   input  logic                   stop_i,
   input  logic                   irq_ack_i,
   input  logic [WIDTH-1:0]       cnt_q_i,
   input  logic                   cnt_overflow_i,
   output logic                   cnt_clear_o,
   output logic                   cnt_en_o,
   output logic                   cnt_load_o,
   output logic                   cnt_down_o,
   output logic [WIDTH-1:0]       cnt_d_o,
   output logic                   running_o,
   output logic                   irq_o,
   output logic                   miss_o,
   output logic                   err_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic                   sh_oneshot_q;
   logic                   sh_down_q;
   logic [PRESC_WIDTH-1:0] sh_presc_q;
   logic [WIDTH-1:0]       sh_cmp_q;
   logic [PRESC_WIDTH-1:0] presc_cnt_q;
   logic                   irq_q, miss_q, err_q;

   logic                   active;
   logic                   stop_req;
   logic                   tick;
   logic                   event_hit;
   logic                   capture;
   logic [WIDTH-1:0]       terminal;

   assign active    = (state_q == S_LOAD) || (state_q == S_RUN);
   assign stop_req  = active && (stop_i || !cfg_en_i);
   assign tick      = (state_q == S_RUN) && (presc_cnt_q == sh_presc_q);
   assign terminal  = sh_down_q ? '0 : sh_cmp_q;
   // A stop in the same cycle wins over the event, so no interrupt is raised.
   assign event_hit = tick && (cnt_q_i == terminal) && !stop_req;
   assign capture   = ((state_q == S_IDLE) || (state_q == S_DONE)) && (state_d == S_LOAD);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_i && cfg_en_i) state_d = S_LOAD;
         end
         S_LOAD: begin
            state_d = stop_req ? S_IDLE : S_RUN;
         end
         S_RUN: begin
            if (stop_req)                       state_d = S_IDLE;
            else if (event_hit && sh_oneshot_q) state_d = S_DONE;
         end
         S_DONE: begin
            if (stop_i)                     state_d = S_IDLE;
            else if (start_i && cfg_en_i)   state_d = S_LOAD;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Counter strobes are suppressed while reset is asserted so an aborted run
   // never emits a clear pulse.
   always_comb begin
      cnt_clear_o = 1'b0;
      cnt_en_o    = 1'b0;
      cnt_load_o  = 1'b0;
      if (!rst_i) begin
         case (state_q)
            S_LOAD: begin
               if (stop_req) cnt_clear_o = 1'b1;
               else          cnt_load_o  = 1'b1;
            end
            S_RUN: begin
               if (stop_req)       cnt_clear_o = 1'b1;
               else if (event_hit) cnt_load_o  = !sh_oneshot_q;
               else if (tick)      cnt_en_o    = 1'b1;
            end
            S_DONE: begin
               if (stop_i) cnt_clear_o = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign cnt_down_o = sh_down_q;
   assign cnt_d_o    = sh_down_q ? sh_cmp_q : '0;
   assign running_o  = active;
   assign irq_o      = irq_q;
   assign miss_o     = miss_q;
   assign err_o      = err_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sh_oneshot_q <= 1'b0;
         sh_down_q    <= 1'b0;
         sh_presc_q   <= '0;
         sh_cmp_q     <= '0;
         presc_cnt_q  <= '0;
         irq_q        <= 1'b0;
         miss_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         if (capture) begin
            sh_oneshot_q <= cfg_oneshot_i;
            sh_down_q    <= cfg_down_i;
            sh_presc_q   <= cfg_presc_i;
            sh_cmp_q     <= cfg_cmp_i;
         end

         if (state_q == S_LOAD) begin
            presc_cnt_q <= '0;
         end else if (state_q == S_RUN) begin
            presc_cnt_q <= tick ? '0 : presc_cnt_q + 1'b1;
         end

         if (state_q == S_LOAD) begin
            err_q <= 1'b0;
         end else if ((state_q == S_RUN) && cnt_overflow_i) begin
            err_q <= 1'b1;
         end

         // A new event outranks a coincident ack: irq stays pending.
         if (event_hit) begin
            irq_q <= 1'b1;
            if (irq_q && !irq_ack_i) miss_q <= 1'b1;
         end else if (irq_ack_i) begin
            irq_q  <= 1'b0;
            miss_q <= 1'b0;
         end
      end
   end

endmodule
